// File: rtl/tdc_pkg.sv
// Shared types and defaults for the TDC measurement controller.
package tdc_pkg;

    localparam int unsigned CntWDefault = 8;
    localparam int unsigned TagW        = 4;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StArmed,
        StRun,
        StStore,
        StWait,
        StDone
    } tdc_state_e;

endpackage

// File: rtl/tdc_meas_ctrl.sv
// Coarse-count TDC measurement sequencer with a result handshake.
// Optional run timeout enabled by defining TDC_MEAS_TIMEOUT_EN.
module tdc_meas_ctrl
    import tdc_pkg::*;
#(
    parameter int unsigned CNT_W   = CntWDefault,
    parameter int unsigned TIMEOUT = 250
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             abort,
    input  logic             start_evt,
    input  logic             stop_evt,
    input  logic [CNT_W-1:0] count_in,
    output logic             cnt_rst,
    output logic             cnt_hit,
    output logic             cnt_store,
    output logic             busy,
    output logic [CNT_W-1:0] res_data,
    output logic             res_ovf,
    output logic [TagW-1:0]  res_tag,
    output logic             res_valid,
    input  logic             res_ready
);

    tdc_state_e state_q, state_d;
    logic       timeout_hit;

`ifdef TDC_MEAS_TIMEOUT_EN
    logic [CNT_W-1:0] run_cnt_q;
    logic             ovf_pend_q;
    logic             res_ovf_q;

    assign timeout_hit = (run_cnt_q == CNT_W'(TIMEOUT - 1));
    assign res_ovf     = res_ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt_q  <= '0;
            ovf_pend_q <= 1'b0;
            res_ovf_q  <= 1'b0;
        end else begin
            if (state_q == StClear) begin
                run_cnt_q <= '0;
            end else if (state_q == StRun) begin
                run_cnt_q <= run_cnt_q + CNT_W'(1);
            end
            // A stop on the timeout cycle wins: the result is a genuine measurement.
            if (state_q == StRun && state_d == StStore) begin
                ovf_pend_q <= timeout_hit && !stop_evt;
            end else if (state_q == StClear) begin
                ovf_pend_q <= 1'b0;
            end
            if (state_q == StWait && state_d == StDone) begin
                res_ovf_q <= ovf_pend_q;
            end else if (state_d != StDone) begin
                res_ovf_q <= 1'b0;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign res_ovf     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (arm) state_d = StClear;
            StClear: state_d = StArmed;
            StArmed: begin
                if (start_evt && stop_evt) begin
                    state_d = StStore;
                end else if (start_evt) begin
                    state_d = StRun;
                end
            end
            StRun:   if (stop_evt || timeout_hit) state_d = StStore;
            StStore: state_d = StWait;
            StWait:  state_d = StDone;
            StDone:  if (res_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d = StIdle;
        end
    end

    // Outputs are registered decodes of the next state, so they track state_q exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_rst   <= 1'b0;
            cnt_hit   <= 1'b0;
            cnt_store <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_tag   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_rst   <= (state_d == StClear);
            cnt_hit   <= (state_d == StRun);
            cnt_store <= (state_d == StStore);
            busy      <= (state_d != StIdle);
            res_valid <= (state_d == StDone);
            if (state_q == StWait && state_d == StDone) begin
                res_data <= count_in;
            end
            if (state_q == StDone && res_ready && !abort) begin
                res_tag <= res_tag + TagW'(1);
            end
        end
    end

endmodule
